// File: rtl/cc_screen_sequencer_pkg.sv
// Shared state encoding and screen-mux select codes for the screen sequencer.
package cc_screen_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_FILL      = 3'd2,
    ST_PLAY      = 3'd3,
    ST_BLINK_ON  = 3'd4,
    ST_BLINK_OFF = 3'd5
  } state_t;

  localparam logic [1:0] SEL_OFF    = 2'd0;
  localparam logic [1:0] SEL_ON     = 2'd1;
  localparam logic [1:0] SEL_RANDOM = 2'd2;

  function automatic logic [1:0] sel_for_state(input state_t s);
    case (s)
      ST_FILL, ST_BLINK_ON: return SEL_ON;
      ST_PLAY:              return SEL_RANDOM;
      default:              return SEL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/cc_screen_sequencer_frame_counter.sv
// Frame-tick counter with synchronous clear and a terminal-count hit flag.
module cc_screen_sequencer_frame_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_terminal,
  output logic             o_hit
);

  logic [WIDTH-1:0] r_count;

  // Hit flags the tick that would bring the count up to the terminal value.
  assign o_hit = i_en && (r_count == (i_terminal - WIDTH'(1)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cc_screen_sequencer.sv
// Frame-synchronous screen sequencer: clear, start flash, play, game-over blink.
module cc_screen_sequencer
  import cc_screen_sequencer_pkg::*;
#(
  parameter int unsigned SEQ_SELECTWIDTH = 8,
  parameter int unsigned SEQ_TICKWIDTH   = 8,
  parameter int unsigned SEQ_CLEAR_TICKS = 4,
  parameter int unsigned SEQ_FILL_TICKS  = 4,
  parameter int unsigned SEQ_BLINK_HALF  = 2,
  parameter int unsigned SEQ_BLINK_COUNT = 3
) (
  input  logic                       CC_SCREENSEQ_CLOCK_50,
  input  logic                       CC_SCREENSEQ_RESET_InLow,
  input  logic                       CC_SCREENSEQ_start_InLow,
  input  logic                       CC_SCREENSEQ_gameover_InHigh,
  input  logic                       CC_SCREENSEQ_frametick_InHigh,
  output logic [SEQ_SELECTWIDTH-1:0] CC_SCREENSEQ_select_OutBUS,
  output logic                       CC_SCREENSEQ_busy_OutHigh,
  output logic                       CC_SCREENSEQ_done_OutHigh
);

  state_t                   r_state;
  state_t                   w_next;
  logic [SEQ_TICKWIDTH-1:0] r_pairs;
  logic [SEQ_TICKWIDTH-1:0] w_terminal;
  logic                     w_tick_en;
  logic                     w_hit;
  logic                     w_clr;
  logic                     w_done;
  logic                     w_pair_inc;
  logic                     w_pair_clr;

  cc_screen_sequencer_frame_counter #(
    .WIDTH(SEQ_TICKWIDTH)
  ) u_frame_counter (
    .i_clk      (CC_SCREENSEQ_CLOCK_50),
    .i_rst_n    (CC_SCREENSEQ_RESET_InLow),
    .i_clr      (w_clr),
    .i_en       (w_tick_en),
    .i_terminal (w_terminal),
    .o_hit      (w_hit)
  );

  always_comb begin
    w_tick_en = 1'b0;
    w_terminal = SEQ_TICKWIDTH'(SEQ_BLINK_HALF);
    case (r_state)
      ST_CLEAR: begin
        w_tick_en  = CC_SCREENSEQ_frametick_InHigh;
        w_terminal = SEQ_TICKWIDTH'(SEQ_CLEAR_TICKS);
      end
      ST_FILL: begin
        w_tick_en  = CC_SCREENSEQ_frametick_InHigh;
        w_terminal = SEQ_TICKWIDTH'(SEQ_FILL_TICKS);
      end
      ST_BLINK_ON, ST_BLINK_OFF: w_tick_en = CC_SCREENSEQ_frametick_InHigh;
      default: ;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_done     = 1'b0;
    w_pair_inc = 1'b0;
    w_pair_clr = 1'b0;
    case (r_state)
      ST_IDLE:  if (!CC_SCREENSEQ_start_InLow) w_next = ST_CLEAR;
      ST_CLEAR: if (w_hit) w_next = ST_FILL;
      ST_FILL:  if (w_hit) w_next = ST_PLAY;
      ST_PLAY: begin
        if (CC_SCREENSEQ_gameover_InHigh) begin
          w_next     = ST_BLINK_ON;
          w_pair_clr = 1'b1;
        end
      end
      ST_BLINK_ON: if (w_hit) w_next = ST_BLINK_OFF;
      ST_BLINK_OFF: begin
        if (w_hit) begin
          if (r_pairs == SEQ_TICKWIDTH'(SEQ_BLINK_COUNT - 1)) begin
            w_next = ST_IDLE;
            w_done = 1'b1;
          end else begin
            w_next     = ST_BLINK_ON;
            w_pair_inc = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Any state change restarts the frame count, so a tick coincident with
  // gameover in PLAY is never carried into the first blink half.
  assign w_clr = (w_next != r_state);

  always_ff @(posedge CC_SCREENSEQ_CLOCK_50) begin
    if (!CC_SCREENSEQ_RESET_InLow) begin
      r_state                    <= ST_IDLE;
      r_pairs                    <= '0;
      CC_SCREENSEQ_select_OutBUS <= '0;
      CC_SCREENSEQ_busy_OutHigh  <= 1'b0;
      CC_SCREENSEQ_done_OutHigh  <= 1'b0;
    end else begin
      r_state                    <= w_next;
      CC_SCREENSEQ_select_OutBUS <= SEQ_SELECTWIDTH'(sel_for_state(w_next));
      CC_SCREENSEQ_busy_OutHigh  <= (w_next != ST_IDLE);
      CC_SCREENSEQ_done_OutHigh  <= w_done;
      if (w_pair_clr) begin
        r_pairs <= '0;
      end else if (w_pair_inc) begin
        r_pairs <= r_pairs + SEQ_TICKWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_cc_screen_sequencer.sv
// Randomized-tick bench for cc_screen_sequencer against a tick-timeline model.
module tb_cc_screen_sequencer;

  localparam int CLR   = 4;
  localparam int FIL   = 4;
  localparam int HALF  = 2;
  localparam int PAIRS = 3;

  logic       clk = 1'b0;
  logic       rst_n, start_n, gameover, tick;
  logic [7:0] sel;
  logic       busy, done;

  cc_screen_sequencer #(
    .SEQ_SELECTWIDTH(8), .SEQ_TICKWIDTH(8), .SEQ_CLEAR_TICKS(CLR),
    .SEQ_FILL_TICKS(FIL), .SEQ_BLINK_HALF(HALF), .SEQ_BLINK_COUNT(PAIRS)
  ) dut (
    .CC_SCREENSEQ_CLOCK_50        (clk),
    .CC_SCREENSEQ_RESET_InLow     (rst_n),
    .CC_SCREENSEQ_start_InLow     (start_n),
    .CC_SCREENSEQ_gameover_InHigh (gameover),
    .CC_SCREENSEQ_frametick_InHigh(tick),
    .CC_SCREENSEQ_select_OutBUS   (sel),
    .CC_SCREENSEQ_busy_OutHigh    (busy),
    .CC_SCREENSEQ_done_OutHigh    (done)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 running (t = ticks since start), 2 game over
  // (b = ticks since gameover). Screen content is a function of t or b.
  int m_mode = 0;
  int m_t = 0;
  int m_b = 0;
  bit m_done = 1'b0;
  int n_total = 0;
  int n_pass = 0;

  function automatic logic [7:0] exp_sel();
    if (m_mode == 1) return (m_t < CLR) ? 8'd0 : (m_t < CLR + FIL) ? 8'd1 : 8'd2;
    if (m_mode == 2) return (((m_b / HALF) % 2) == 0) ? 8'd1 : 8'd0;
    return 8'd0;
  endfunction

  task automatic model_edge();
    m_done = 1'b0;
    if (!rst_n) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (!start_n) begin m_mode = 1; m_t = 0; end
    end else if (m_mode == 1) begin
      if (m_t >= CLR + FIL) begin
        if (gameover) begin m_mode = 2; m_b = 0; end
      end else if (tick) begin
        m_t++;
      end
    end else begin
      if (tick) m_b++;
      if (m_b == 2 * HALF * PAIRS) begin m_mode = 0; m_done = 1'b1; end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
  endtask

  task automatic cyc(input logic r, input logic s, input logic g, input logic t);
    rst_n = r; start_n = s; gameover = g; tick = t;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("select", sel, exp_sel());
    check("busy", {7'd0, busy}, {7'd0, m_mode != 0});
    check("done", {7'd0, done}, {7'd0, m_done});
  endtask

  function automatic logic rtick();
    return ($urandom_range(0, 2) == 0);
  endfunction

  task automatic reached(input string tag, input bit ok);
    n_total++;
    assert (ok) n_pass++;
    else $error("FAIL %s: observed timeout expected condition reached", tag);
  endtask

  initial begin
    rst_n = 1'b0; start_n = 1'b1; gameover = 1'b0; tick = 1'b0;
    @(negedge clk);

    // Reset then idle with random ticks and no start
    repeat (3) cyc(1'b0, 1'b1, 1'b0, rtick());
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1, 1'b0, rtick());

    // Nominal start, stray start presses during play, single gameover pulse
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400 && !(m_mode == 1 && m_t >= CLR + FIL); i++)
      cyc(1'b1, 1'b1, 1'b0, rtick());
    reached("reach_play", m_mode == 1 && m_t >= CLR + FIL);
    for (int i = 0; i < 10; i++) cyc(1'b1, (i % 3) != 0, 1'b0, rtick());
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 400 && m_mode != 0; i++) cyc(1'b1, 1'b1, 1'b0, rtick());
    reached("blink_end", m_mode == 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, rtick());

    // Gameover coincident with a tick; gameover held high into idle
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400 && !(m_mode == 1 && m_t >= CLR + FIL); i++)
      cyc(1'b1, 1'b1, 1'b0, rtick());
    reached("reach_play2", m_mode == 1 && m_t >= CLR + FIL);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 400 && m_mode != 0; i++) cyc(1'b1, 1'b1, 1'b1, rtick());
    reached("blink_end2", m_mode == 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, rtick());

    // Reset mid-FILL after two fill ticks, then a full fresh run
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400 && !(m_mode == 1 && m_t == CLR + 2); i++)
      cyc(1'b1, 1'b1, 1'b0, rtick());
    reached("reach_fill2", m_mode == 1 && m_t == CLR + 2);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, rtick());
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400 && !(m_mode == 1 && m_t >= CLR + FIL); i++)
      cyc(1'b1, 1'b1, 1'b0, rtick());
    reached("reach_play3", m_mode == 1 && m_t >= CLR + FIL);

    // Start held low across a whole game: restart right after done
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, rtick());
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 400 && !m_done; i++) cyc(1'b1, 1'b0, 1'b0, rtick());
    reached("done_held", m_done);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    reached("reenter_clear", m_mode == 1 && m_t == 0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
